// File: rtl/pipe_hazard_scoreboard.sv
// Pending-write scoreboard for the stages after ID: forwarding selects, load-use stall, bubble/flush update.
// Optional 16-bit saturating stall counter is compiled in when HAZ_STALL_CNT_EN is defined.
module pipe_hazard_scoreboard #(
   parameter  int RID_W       = 3,
   parameter  int STAGES      = 3,
   parameter  int LOAD_READY  = 2,
   parameter  int FLUSH_DEPTH = 1,
   localparam int SEL_W       = $clog2(STAGES + 1)
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               hold,
   input  logic               flush,
   input  logic               id_valid,
   input  logic               id_wr,
   input  logic               id_load,
   input  logic [RID_W-1:0]   id_rd,
   input  logic               id_src_a_en,
   input  logic [RID_W-1:0]   id_src_a,
   input  logic               id_src_b_en,
   input  logic [RID_W-1:0]   id_src_b,
   output logic               stall,
   output logic [SEL_W-1:0]   fwd_a,
   output logic [SEL_W-1:0]   fwd_b,
   output logic [STAGES-1:0]  pending,
   output logic [15:0]        stall_count
);

   // Bit k-1 of each vector describes stage k (stage 1 = EX).
   logic [STAGES-1:0]            v_q, v_d;
   logic [STAGES-1:0]            ld_q, ld_d;
   logic [STAGES-1:0][RID_W-1:0] rd_q, rd_d;

   logic [SEL_W-1:0] sel_a, sel_b;
   logic             late;

   // Scanning from oldest to youngest lets the youngest producer overwrite older matches.
   always_comb begin
      sel_a = '0;
      sel_b = '0;
      late  = 1'b0;
      for (int k = STAGES; k >= 1; k--) begin
         if (id_src_a_en && v_q[k-1] && rd_q[k-1] == id_src_a) sel_a = SEL_W'(k);
         if (id_src_b_en && v_q[k-1] && rd_q[k-1] == id_src_b) sel_b = SEL_W'(k);
      end
      for (int k = 1; k <= STAGES; k++) begin
         if ((sel_a == SEL_W'(k) || sel_b == SEL_W'(k)) && ld_q[k-1] && k < LOAD_READY)
            late = 1'b1;
      end
   end

   assign stall   = late & ~flush;
   assign fwd_a   = sel_a;
   assign fwd_b   = sel_b;
   assign pending = v_q;

   // Stall and flush both leave entry 1 empty because the issue valid is gated by them.
   always_comb begin
      v_d  = v_q;
      ld_d = ld_q;
      rd_d = rd_q;
      if (!hold) begin
         v_d  = {v_q[STAGES-2:0], id_valid & id_wr & ~stall & ~flush};
         ld_d = {ld_q[STAGES-2:0], id_load};
         rd_d = {rd_q[STAGES-2:0], id_rd};
         if (flush) begin
            for (int k = 0; k < FLUSH_DEPTH; k++) v_d[k] = 1'b0;
         end
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         v_q  <= '0;
         ld_q <= '0;
         rd_q <= '0;
      end else begin
         v_q  <= v_d;
         ld_q <= ld_d;
         rd_q <= rd_d;
      end
   end

`ifdef HAZ_STALL_CNT_EN
   logic [15:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (stall && !hold && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end

   assign stall_count = cnt_q;
`else
   assign stall_count = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// Bench for pipe_hazard_scoreboard: directed scenarios plus random traffic against an
// instruction-level model of the in-flight writers.
module tb_pipe_hazard_scoreboard;
   localparam int RID_W       = 3;
   localparam int STAGES      = 3;
   localparam int LOAD_READY  = 2;
   localparam int FLUSH_DEPTH = 1;
   localparam int SEL_W       = $clog2(STAGES + 1);

   logic              CLK = 1'b0;
   logic              RST = 1'b0;
   logic              hold, flush, id_valid, id_wr, id_load;
   logic [RID_W-1:0]  id_rd, id_src_a, id_src_b;
   logic              id_src_a_en, id_src_b_en;
   logic              stall;
   logic [SEL_W-1:0]  fwd_a, fwd_b;
   logic [STAGES-1:0] pending;
   logic [15:0]       stall_count;

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   pipe_hazard_scoreboard #(
      .RID_W(RID_W), .STAGES(STAGES), .LOAD_READY(LOAD_READY), .FLUSH_DEPTH(FLUSH_DEPTH)
   ) dut (
      .CLK(CLK), .RST(RST), .hold(hold), .flush(flush),
      .id_valid(id_valid), .id_wr(id_wr), .id_load(id_load), .id_rd(id_rd),
      .id_src_a_en(id_src_a_en), .id_src_a(id_src_a),
      .id_src_b_en(id_src_b_en), .id_src_b(id_src_b),
      .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b),
      .pending(pending), .stall_count(stall_count)
   );

   // Model: one record per post-decode stage, index 1..STAGES.
   typedef struct { bit v; bit ld; int rd; } ent_t;
   ent_t sb [STAGES+1];
   int   exp_cnt;

   function automatic int m_fwd(input bit en, input int src);
      for (int k = 1; k <= STAGES; k++)
         if (en && sb[k].v && sb[k].rd == src) return k;
      return 0;
   endfunction

   function automatic bit m_late(input int k);
      return (k != 0) && sb[k].ld && (k < LOAD_READY);
   endfunction

   function automatic bit m_stall();
      return !flush && (m_late(m_fwd(id_src_a_en, int'(id_src_a))) ||
                        m_late(m_fwd(id_src_b_en, int'(id_src_b))));
   endfunction

   function automatic logic [STAGES-1:0] m_pending();
      logic [STAGES-1:0] p;
      for (int k = 1; k <= STAGES; k++) p[k-1] = sb[k].v;
      return p;
   endfunction

   function automatic logic [15:0] m_cnt();
`ifdef HAZ_STALL_CNT_EN
      return 16'(exp_cnt);
`else
      return 16'h0000;
`endif
   endfunction

   task automatic model_reset();
      for (int k = 0; k <= STAGES; k++) sb[k] = '{v: 1'b0, ld: 1'b0, rd: 0};
      exp_cnt = 0;
   endtask

   task automatic drive(input bit v, input bit wr, input bit ld, input int rd,
                        input bit aen, input int a, input bit ben, input int b,
                        input bit h, input bit f);
      id_valid = v; id_wr = wr; id_load = ld; id_rd = RID_W'(rd);
      id_src_a_en = aen; id_src_a = RID_W'(a);
      id_src_b_en = ben; id_src_b = RID_W'(b);
      hold = h; flush = f;
   endtask

   // Apply one clock edge to the model in the priority order hold > flush > stall > issue.
   task automatic advance();
      bit s;
      s = m_stall();
      if (!hold) begin
`ifdef HAZ_STALL_CNT_EN
         if (s && exp_cnt < 65535) exp_cnt++;
`endif
         for (int k = STAGES; k >= 2; k--) sb[k] = sb[k-1];
         if (flush) begin
            for (int k = 1; k <= FLUSH_DEPTH; k++) sb[k].v = 1'b0;
            sb[1].v = 1'b0;
         end else if (s) begin
            sb[1].v = 1'b0;
         end else begin
            sb[1] = '{v: id_valid && id_wr, ld: id_load, rd: int'(id_rd)};
         end
      end
      @(posedge CLK);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
         advance();
      end
   endtask

   task automatic test_reset();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      model_reset();
      #12;
      checks += 4;
      if (pending !== 3'b000) begin errors++; $display("FAIL reset_pending got=%b exp=000", pending); end
      if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall); end
      if (fwd_a !== '0 || fwd_b !== '0) begin errors++; $display("FAIL reset_fwd got=%0d/%0d exp=0/0", fwd_a, fwd_b); end
      if (stall_count !== 16'h0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", stall_count); end
      @(negedge CLK);
      RST = 1'b1;
      @(posedge CLK);
      #1;
   endtask

   task automatic test_forward();
      drive(1, 1, 0, 3, 0, 0, 0, 0, 0, 0);
      advance();
      drive(1, 0, 0, 0, 1, 3, 0, 0, 0, 0);
      @(negedge CLK);
      checks += 2;
      if (fwd_a !== SEL_W'(1)) begin errors++; $display("FAIL fwd_stage1 got=%0d exp=1", fwd_a); end
      if (stall !== 1'b0) begin errors++; $display("FAIL fwd_nostall got=%b exp=0", stall); end
      advance();
      drive(1, 0, 0, 0, 0, 0, 1, 3, 0, 0);
      @(negedge CLK);
      checks++;
      if (fwd_b !== SEL_W'(2)) begin errors++; $display("FAIL fwd_stage2_b got=%0d exp=2", fwd_b); end
      advance();
      idle(STAGES);
   endtask

   task automatic test_load_use();
      int cnt0;
      logic [15:0] exp_c;
      cnt0 = exp_cnt;
      drive(1, 1, 1, 2, 0, 0, 0, 0, 0, 0);
      advance();
      drive(1, 0, 0, 0, 1, 2, 0, 0, 0, 0);
      @(negedge CLK);
      checks += 2;
      if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall got=%b exp=1", stall); end
      if (fwd_a !== SEL_W'(1)) begin errors++; $display("FAIL lu_fwd_during_stall got=%0d exp=1", fwd_a); end
      advance();
      @(negedge CLK);
`ifdef HAZ_STALL_CNT_EN
      exp_c = 16'(cnt0 + 1);
`else
      exp_c = 16'h0000;
`endif
      checks += 4;
      if (pending !== 3'b010) begin errors++; $display("FAIL lu_pending got=%b exp=010", pending); end
      if (stall !== 1'b0) begin errors++; $display("FAIL lu_release got=%b exp=0", stall); end
      if (fwd_a !== SEL_W'(2)) begin errors++; $display("FAIL lu_fwd_after got=%0d exp=2", fwd_a); end
      if (stall_count !== exp_c) begin errors++; $display("FAIL lu_count got=%0d exp=%0d", stall_count, exp_c); end
      advance();
      idle(STAGES);
   endtask

   task automatic test_youngest();
      drive(1, 1, 0, 5, 0, 0, 0, 0, 0, 0); advance();
      drive(1, 1, 0, 5, 0, 0, 0, 0, 0, 0); advance();
      drive(1, 0, 0, 0, 1, 5, 0, 0, 0, 0);
      @(negedge CLK);
      checks++;
      if (fwd_a !== SEL_W'(1)) begin errors++; $display("FAIL young_b2b got=%0d exp=1", fwd_a); end
      advance();
      idle(STAGES);
      drive(1, 1, 0, 5, 0, 0, 0, 0, 0, 0); advance();
      idle(1);
      drive(1, 1, 0, 5, 0, 0, 0, 0, 0, 0); advance();
      drive(1, 0, 0, 0, 1, 5, 0, 0, 0, 0);
      @(negedge CLK);
      checks += 2;
      if (fwd_a !== SEL_W'(1)) begin errors++; $display("FAIL young_gap got=%0d exp=1", fwd_a); end
      if (pending !== 3'b101) begin errors++; $display("FAIL young_pending got=%b exp=101", pending); end
      advance();
      idle(STAGES);
   endtask

   task automatic test_flush();
      drive(1, 1, 0, 4, 0, 0, 0, 0, 0, 1);
      advance();
      drive(1, 0, 0, 0, 1, 4, 0, 0, 0, 0);
      @(negedge CLK);
      checks += 2;
      if (pending[0] !== 1'b0) begin errors++; $display("FAIL flush_drop_pending got=%b exp=0", pending[0]); end
      if (fwd_a !== '0) begin errors++; $display("FAIL flush_drop_fwd got=%0d exp=0", fwd_a); end
      advance();
      idle(STAGES);
      drive(1, 1, 0, 6, 0, 0, 0, 0, 0, 0); advance();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); advance();
      drive(1, 0, 0, 0, 1, 6, 0, 0, 0, 0);
      @(negedge CLK);
      checks += 2;
      if (pending !== 3'b010) begin errors++; $display("FAIL flush_shift_pending got=%b exp=010", pending); end
      if (fwd_a !== SEL_W'(2)) begin errors++; $display("FAIL flush_shift_fwd got=%0d exp=2", fwd_a); end
      advance();
      idle(STAGES);
      drive(1, 1, 1, 7, 0, 0, 0, 0, 0, 0); advance();
      drive(1, 0, 0, 0, 1, 7, 0, 0, 0, 1);
      @(negedge CLK);
      checks++;
      if (stall !== 1'b0) begin errors++; $display("FAIL flush_gates_stall got=%b exp=0", stall); end
      advance();
      idle(STAGES);
   endtask

   task automatic test_hold();
      logic [15:0] c0;
      c0 = stall_count;
      drive(1, 1, 0, 1, 0, 0, 0, 0, 0, 0); advance();
      idle(1);
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 0, 0, 1, 1, 0, 0, 1, 0);
         @(negedge CLK);
         checks += 3;
         if (pending !== 3'b010) begin errors++; $display("FAIL hold_pending cyc=%0d got=%b exp=010", i, pending); end
         if (fwd_a !== SEL_W'(2)) begin errors++; $display("FAIL hold_fwd cyc=%0d got=%0d exp=2", i, fwd_a); end
         if (stall_count !== m_cnt()) begin errors++; $display("FAIL hold_cnt cyc=%0d got=%0d exp=%0d", i, stall_count, m_cnt()); end
         advance();
      end
      idle(STAGES);
      c0 = m_cnt();
      drive(1, 1, 1, 2, 0, 0, 0, 0, 0, 0); advance();
      for (int i = 0; i < 2; i++) begin
         drive(1, 0, 0, 0, 0, 0, 1, 2, 1, 0);
         @(negedge CLK);
         checks += 2;
         if (stall !== 1'b1) begin errors++; $display("FAIL hold_stall cyc=%0d got=%b exp=1", i, stall); end
         if (stall_count !== c0) begin errors++; $display("FAIL hold_stall_cnt cyc=%0d got=%0d exp=%0d", i, stall_count, c0); end
         advance();
      end
      drive(1, 0, 0, 0, 0, 0, 1, 2, 0, 0);
      advance();
      @(negedge CLK);
      checks++;
      if (stall_count !== m_cnt()) begin errors++; $display("FAIL hold_release_cnt got=%0d exp=%0d", stall_count, m_cnt()); end
      advance();
      idle(STAGES);
   endtask

   task automatic test_async_reset();
      drive(1, 1, 0, 1, 0, 0, 0, 0, 0, 0); advance();
      drive(1, 1, 0, 2, 0, 0, 0, 0, 0, 0); advance();
      drive(1, 1, 1, 3, 0, 0, 0, 0, 0, 0); advance();
      drive(1, 0, 0, 0, 1, 3, 0, 0, 0, 0);
      @(negedge CLK);
      checks += 2;
      if (pending !== 3'b111) begin errors++; $display("FAIL ar_pre_pending got=%b exp=111", pending); end
      if (stall !== 1'b1) begin errors++; $display("FAIL ar_pre_stall got=%b exp=1", stall); end
      #2;
      RST = 1'b0;
      #1;
      model_reset();
      checks += 4;
      if (pending !== 3'b000) begin errors++; $display("FAIL ar_pending got=%b exp=000", pending); end
      if (stall !== 1'b0) begin errors++; $display("FAIL ar_stall got=%b exp=0", stall); end
      if (fwd_a !== '0) begin errors++; $display("FAIL ar_fwd got=%0d exp=0", fwd_a); end
      if (stall_count !== 16'h0) begin errors++; $display("FAIL ar_cnt got=%0d exp=0", stall_count); end
      @(posedge CLK);
      @(negedge CLK);
      RST = 1'b1;
      advance();
      drive(1, 0, 0, 0, 1, 1, 1, 2, 0, 0);
      @(negedge CLK);
      checks += 2;
      if (fwd_a !== '0) begin errors++; $display("FAIL ar_after_fwd_a got=%0d exp=0", fwd_a); end
      if (fwd_b !== '0) begin errors++; $display("FAIL ar_after_fwd_b got=%0d exp=0", fwd_b); end
      advance();
      idle(STAGES);
   endtask

   task automatic test_random();
      int ea, eb;
      bit es;
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
               $urandom_range(0, 3), $urandom_range(0, 1) == 1, $urandom_range(0, 3),
               $urandom_range(0, 1) == 1, $urandom_range(0, 3),
               $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
         @(negedge CLK);
         ea = m_fwd(id_src_a_en, int'(id_src_a));
         eb = m_fwd(id_src_b_en, int'(id_src_b));
         es = m_stall();
         checks += 5;
         if (stall !== es) begin errors++; $display("FAIL rnd_stall i=%0d got=%b exp=%b", i, stall, es); end
         if (fwd_a !== SEL_W'(ea)) begin errors++; $display("FAIL rnd_fwd_a i=%0d got=%0d exp=%0d", i, fwd_a, ea); end
         if (fwd_b !== SEL_W'(eb)) begin errors++; $display("FAIL rnd_fwd_b i=%0d got=%0d exp=%0d", i, fwd_b, eb); end
         if (pending !== m_pending()) begin errors++; $display("FAIL rnd_pending i=%0d got=%b exp=%b", i, pending, m_pending()); end
         if (stall_count !== m_cnt()) begin errors++; $display("FAIL rnd_cnt i=%0d got=%0d exp=%0d", i, stall_count, m_cnt()); end
         advance();
      end
   endtask

   initial begin
      test_reset();
      test_forward();
      test_load_use();
      test_youngest();
      test_flush();
      test_hold();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
